// File: rtl/dual_wb_regfile.sv
// dual_wb_regfile: 32x32 architectural register file fed by the dual writeback
// bus. Four combinational read ports with write-through bypass, plus a
// per-register pending-write scoreboard used by issue to detect RAW hazards.
module dual_wb_regfile #(
  parameter int CNT_W           = 2,
  parameter int WS_TO_RF_BUS_WD = 76
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
  input  logic [4:0]                 raddr0,
  input  logic [4:0]                 raddr1,
  input  logic [4:0]                 raddr2,
  input  logic [4:0]                 raddr3,
  output logic [31:0]                rdata0,
  output logic [31:0]                rdata1,
  output logic [31:0]                rdata2,
  output logic [31:0]                rdata3,
  output logic                       rbusy0,
  output logic                       rbusy1,
  output logic                       rbusy2,
  output logic                       rbusy3,
  input  logic                       iss_valid1,
  input  logic                       iss_valid2,
  input  logic                       iss_we1,
  input  logic                       iss_we2,
  input  logic [4:0]                 iss_dest1,
  input  logic [4:0]                 iss_dest2,
  input  logic                       flush,
  output logic                       sb_overflow
);

  // Counter arithmetic is done two bits wider so both underflow (sign bit)
  // and overflow past the saturation value are visible.
  localparam int              CW      = CNT_W + 2;
  localparam logic [CW-1:0]   CNT_MAX = CW'((1 << CNT_W) - 1);

  logic        we1_s, we2_s;
  logic [4:0]  waddr1_s, waddr2_s;
  logic [31:0] wdata1_s, wdata2_s;

  assign we1_s    = ws_to_rf_bus[75];
  assign waddr1_s = ws_to_rf_bus[74:70];
  assign wdata1_s = ws_to_rf_bus[69:38];
  assign we2_s    = ws_to_rf_bus[37];
  assign waddr2_s = ws_to_rf_bus[36:32];
  assign wdata2_s = ws_to_rf_bus[31:0];

  logic [31:0]      gpr_r     [32];
  logic [CNT_W-1:0] cnt_r     [32];
  logic [1:0]       inc_s     [32];
  logic [1:0]       dec_s     [32];
  logic [CW-1:0]    sum_s     [32];
  logic [CNT_W-1:0] cnt_nxt_s [32];
  logic             ovf_hit_s;

  logic [4:0]  raddr_s [4];
  logic [31:0] rdata_s [4];
  logic        rbusy_s [4];

  assign raddr_s[0] = raddr0;
  assign raddr_s[1] = raddr1;
  assign raddr_s[2] = raddr2;
  assign raddr_s[3] = raddr3;

  assign rdata0 = rdata_s[0];
  assign rdata1 = rdata_s[1];
  assign rdata2 = rdata_s[2];
  assign rdata3 = rdata_s[3];
  assign rbusy0 = rbusy_s[0];
  assign rbusy1 = rbusy_s[1];
  assign rbusy2 = rbusy_s[2];
  assign rbusy3 = rbusy_s[3];

  // Per-register issue/retire counts and the saturated next counter value.
  always_comb begin
    ovf_hit_s    = 1'b0;
    inc_s[0]     = 2'd0;
    dec_s[0]     = 2'd0;
    sum_s[0]     = {CW{1'b0}};
    cnt_nxt_s[0] = {CNT_W{1'b0}};
    for (int r = 1; r < 32; r++) begin
      inc_s[r] = {1'b0, iss_valid1 && iss_we1 && (iss_dest1 == 5'(r))}
               + {1'b0, iss_valid2 && iss_we2 && (iss_dest2 == 5'(r))};
      dec_s[r] = {1'b0, we1_s && (waddr1_s == 5'(r))}
               + {1'b0, we2_s && (waddr2_s == 5'(r))};
      sum_s[r] = CW'(cnt_r[r]) + CW'(inc_s[r]) - CW'(dec_s[r]);
      if (sum_s[r][CW-1]) begin
        // Retire without a recorded issue: clamp at zero.
        cnt_nxt_s[r] = {CNT_W{1'b0}};
      end else if (sum_s[r] > CNT_MAX) begin
        cnt_nxt_s[r] = CNT_MAX[CNT_W-1:0];
        ovf_hit_s    = 1'b1;
      end else begin
        cnt_nxt_s[r] = sum_s[r][CNT_W-1:0];
      end
    end
  end

  // Read ports: r0 is hard zero, channel 2 bypass beats channel 1, then array.
  // Busy looks at the counter after this cycle's writebacks retire.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      if (raddr_s[p] == 5'd0) begin
        rdata_s[p] = 32'd0;
        rbusy_s[p] = 1'b0;
      end else begin
        if (we2_s && (waddr2_s == raddr_s[p])) begin
          rdata_s[p] = wdata2_s;
        end else if (we1_s && (waddr1_s == raddr_s[p])) begin
          rdata_s[p] = wdata1_s;
        end else begin
          rdata_s[p] = gpr_r[raddr_s[p]];
        end
        rbusy_s[p] = ((CW'(cnt_r[raddr_s[p]]) - CW'(dec_s[raddr_s[p]])) != {CW{1'b0}});
      end
    end
  end

  // Architectural state: GPR writes (channel 2 younger), counters, sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        gpr_r[r] <= 32'd0;
        cnt_r[r] <= {CNT_W{1'b0}};
      end
      sb_overflow <= 1'b0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (we2_s && (waddr2_s == 5'(r))) begin
          gpr_r[r] <= wdata2_s;
        end else if (we1_s && (waddr1_s == 5'(r))) begin
          gpr_r[r] <= wdata1_s;
        end
      end
      for (int r = 0; r < 32; r++) begin
        cnt_r[r] <= flush ? {CNT_W{1'b0}} : cnt_nxt_s[r];
      end
      if (ovf_hit_s) begin
        sb_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dual_wb_regfile.sv
// Self-checking bench for dual_wb_regfile: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model (value array + integer pending counts).
module tb_dual_wb_regfile;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        we1, we2;
  logic [4:0]  waddr1, waddr2;
  logic [31:0] wdata1, wdata2;
  logic [75:0] ws_to_rf_bus;
  logic [4:0]  ra [4];
  logic [31:0] rdata0, rdata1, rdata2, rdata3;
  logic        rbusy0, rbusy1, rbusy2, rbusy3;
  logic        iss_valid1, iss_valid2, iss_we1, iss_we2;
  logic [4:0]  iss_dest1, iss_dest2;
  logic        flush;
  logic        sb_overflow;

  logic [31:0] rd_w [4];
  logic        rb_w [4];

  int checks = 0;
  int errors = 0;
  int proto_notes = 0;

  // Model state
  logic [31:0] gpr_m [32];
  int          cnt_m [32];
  logic        ovf_m;

  assign ws_to_rf_bus = {we1, waddr1, wdata1, we2, waddr2, wdata2};
  assign rd_w[0] = rdata0;
  assign rd_w[1] = rdata1;
  assign rd_w[2] = rdata2;
  assign rd_w[3] = rdata3;
  assign rb_w[0] = rbusy0;
  assign rb_w[1] = rbusy1;
  assign rb_w[2] = rbusy2;
  assign rb_w[3] = rbusy3;

  always #5 clk = ~clk;

  dual_wb_regfile #(.CNT_W(CNT_W), .WS_TO_RF_BUS_WD(76)) dut (
    .clk(clk), .reset(reset), .ws_to_rf_bus(ws_to_rf_bus),
    .raddr0(ra[0]), .raddr1(ra[1]), .raddr2(ra[2]), .raddr3(ra[3]),
    .rdata0(rdata0), .rdata1(rdata1), .rdata2(rdata2), .rdata3(rdata3),
    .rbusy0(rbusy0), .rbusy1(rbusy1), .rbusy2(rbusy2), .rbusy3(rbusy3),
    .iss_valid1(iss_valid1), .iss_valid2(iss_valid2),
    .iss_we1(iss_we1), .iss_we2(iss_we2),
    .iss_dest1(iss_dest1), .iss_dest2(iss_dest2),
    .flush(flush), .sb_overflow(sb_overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int wb_hits(input int a);
    int n = 0;
    if (we1 && int'(waddr1) == a) n++;
    if (we2 && int'(waddr2) == a) n++;
    return n;
  endfunction

  function automatic int iss_hits(input int a);
    int n = 0;
    if (iss_valid1 && iss_we1 && int'(iss_dest1) == a) n++;
    if (iss_valid2 && iss_we2 && int'(iss_dest2) == a) n++;
    return n;
  endfunction

  function automatic logic [31:0] exp_rd(input int a);
    if (a == 0) return 32'd0;
    if (we2 && int'(waddr2) == a) return wdata2;
    if (we1 && int'(waddr1) == a) return wdata1;
    return gpr_m[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (a == 0) return 1'b0;
    return (cnt_m[a] - wb_hits(a)) != 0;
  endfunction

  // Compare all outputs against the model mid-cycle.
  task automatic check_cycle();
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("rdata%0d(r%0d)", p, ra[p]), rd_w[p], exp_rd(int'(ra[p])));
      chk($sformatf("rbusy%0d(r%0d)", p, ra[p]), {31'd0, rb_w[p]}, {31'd0, exp_busy(int'(ra[p]))});
    end
    chk("sb_overflow", {31'd0, sb_overflow}, {31'd0, ovf_m});
  endtask

  // Advance one clock edge and apply the same edge to the model.
  task automatic commit();
    @(posedge clk);
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        gpr_m[r] = 32'd0;
        cnt_m[r] = 0;
      end
      ovf_m = 1'b0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        int v;
        v = cnt_m[r] + iss_hits(r) - wb_hits(r);
        if (v < 0) begin
          proto_notes++;
          $display("note: protocol error, writeback to r%0d with no pending issue", r);
          v = 0;
        end
        if (v > CNT_MAX) begin
          v = CNT_MAX;
          ovf_m = 1'b1;
        end
        cnt_m[r] = flush ? 0 : v;
      end
      if (we1 && waddr1 != 5'd0) gpr_m[waddr1] = wdata1;
      if (we2 && waddr2 != 5'd0) gpr_m[waddr2] = wdata2;
    end
    #1;
  endtask

  task automatic clear_ctl();
    reset = 1'b0; flush = 1'b0;
    we1 = 1'b0; we2 = 1'b0; waddr1 = 5'd0; waddr2 = 5'd0; wdata1 = 32'd0; wdata2 = 32'd0;
    iss_valid1 = 1'b0; iss_valid2 = 1'b0; iss_we1 = 1'b0; iss_we2 = 1'b0;
    iss_dest1 = 5'd0; iss_dest2 = 5'd0;
  endtask

  task automatic set_ra(input logic [4:0] a);
    for (int p = 0; p < 4; p++) ra[p] = a;
  endtask

  task automatic issue1(input logic [4:0] d);
    iss_valid1 = 1'b1; iss_we1 = 1'b1; iss_dest1 = d;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      gpr_m[r] = 32'd0;
      cnt_m[r] = 0;
    end
    ovf_m = 1'b0;
    clear_ctl();
    set_ra(5'd0);
    reset = 1'b1;
    commit();
    commit();
    reset = 1'b0;

    // Reset state
    set_ra(5'd0);
    check_cycle();
    chk("reset_rdata0", rdata0, 32'd0);
    chk("reset_rbusy0", {31'd0, rbusy0}, 32'd0);
    commit();
    set_ra(5'd5);
    check_cycle();
    chk("r5_rdata3_after_reset", rdata3, 32'd0);
    chk("r5_rbusy2_after_reset", {31'd0, rbusy2}, 32'd0);
    commit();

    // Bypass then array read of r5
    we1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'h12345678;
    check_cycle();
    chk("r5_bypass", rdata0, 32'h12345678);
    commit();
    clear_ctl();
    check_cycle();
    chk("r5_array", rdata0, 32'h12345678);
    commit();

    // Both channels write r7: channel 2 wins
    set_ra(5'd7);
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'hAAAA0000;
    we2 = 1'b1; waddr2 = 5'd7; wdata2 = 32'h5555FFFF;
    check_cycle();
    chk("r7_bypass_ch2_wins", rdata1, 32'h5555FFFF);
    commit();
    clear_ctl();
    check_cycle();
    chk("r7_array_ch2_wins", rdata1, 32'h5555FFFF);
    commit();

    // r0 writes are ignored
    set_ra(5'd0);
    we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF;
    we2 = 1'b1; waddr2 = 5'd0; wdata2 = 32'hFFFFFFFF;
    check_cycle();
    chk("r0_write_bypass", rdata0, 32'd0);
    chk("r0_write_busy", {31'd0, rbusy0}, 32'd0);
    commit();
    clear_ctl();
    check_cycle();
    chk("r0_after_write", rdata2, 32'd0);
    commit();

    // Single issue then writeback of r3
    set_ra(5'd3);
    issue1(5'd3);
    check_cycle();
    chk("r3_issue_same_cycle_not_busy", {31'd0, rbusy0}, 32'd0);
    commit();
    clear_ctl();
    check_cycle();
    chk("r3_busy_after_issue", {31'd0, rbusy0}, 32'd1);
    commit();
    we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'hCAFE0003;
    check_cycle();
    chk("r3_wb_cycle_not_busy", {31'd0, rbusy0}, 32'd0);
    chk("r3_wb_cycle_data", rdata0, 32'hCAFE0003);
    commit();
    clear_ctl();
    check_cycle();
    chk("r3_cnt_zero", {31'd0, rbusy1}, 32'd0);
    commit();

    // Dual issue of r9, staged retirement, issue+retire in same cycle
    set_ra(5'd9);
    issue1(5'd9);
    iss_valid2 = 1'b1; iss_we2 = 1'b1; iss_dest2 = 5'd9;
    check_cycle();
    commit();
    clear_ctl();
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h00000901;
    check_cycle();
    chk("r9_one_wb_still_busy", {31'd0, rbusy0}, 32'd1);
    commit();
    clear_ctl();
    issue1(5'd9);
    we2 = 1'b1; waddr2 = 5'd9; wdata2 = 32'h00000902;
    check_cycle();
    chk("r9_issue_plus_wb_busy", {31'd0, rbusy3}, 32'd0);
    commit();
    clear_ctl();
    check_cycle();
    chk("r9_cnt_unchanged", {31'd0, rbusy2}, 32'd1);
    chk("r9_data", rdata2, 32'h00000902);
    commit();
    we2 = 1'b1; waddr2 = 5'd9; wdata2 = 32'h00000903;
    check_cycle();
    chk("r9_last_wb_not_busy", {31'd0, rbusy0}, 32'd0);
    commit();
    clear_ctl();

    // Saturation of r4, flush, reset
    set_ra(5'd4);
    for (int i = 0; i < 4; i++) begin
      issue1(5'd4);
      check_cycle();
      if (i == 3) chk("ovf_clear_before_4th", {31'd0, sb_overflow}, 32'd0);
      commit();
    end
    clear_ctl();
    check_cycle();
    chk("r4_overflow_set", {31'd0, sb_overflow}, 32'd1);
    chk("r4_busy_saturated", {31'd0, rbusy0}, 32'd1);
    commit();
    flush = 1'b1;
    issue1(5'd4);
    check_cycle();
    commit();
    clear_ctl();
    check_cycle();
    chk("flush_r4_not_busy", {31'd0, rbusy0}, 32'd0);
    chk("flush_keeps_overflow", {31'd0, sb_overflow}, 32'd1);
    commit();
    reset = 1'b1;
    check_cycle();
    commit();
    clear_ctl();
    check_cycle();
    chk("reset_clears_overflow", {31'd0, sb_overflow}, 32'd0);
    commit();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      int need;
      reset = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 24) == 0);
      iss_valid1 = 1'($urandom_range(0, 1));
      iss_valid2 = 1'($urandom_range(0, 1));
      iss_we1    = 1'($urandom_range(0, 1));
      iss_we2    = 1'($urandom_range(0, 1));
      iss_dest1  = 5'($urandom_range(0, 15));
      iss_dest2  = 5'($urandom_range(0, 15));
      waddr1 = 5'($urandom_range(0, 15));
      waddr2 = 5'($urandom_range(0, 15));
      wdata1 = $urandom;
      wdata2 = $urandom;
      we1 = 1'($urandom_range(0, 1));
      we2 = 1'($urandom_range(0, 1));
      if (we1 && waddr1 != 5'd0 && cnt_m[waddr1] < 1) we1 = 1'b0;
      need = (we1 && waddr1 == waddr2) ? 2 : 1;
      if (we2 && waddr2 != 5'd0 && cnt_m[waddr2] < need) we2 = 1'b0;
      for (int p = 0; p < 4; p++) begin
        case ($urandom_range(0, 3))
          0:       ra[p] = waddr1;
          1:       ra[p] = waddr2;
          default: ra[p] = 5'($urandom_range(0, 31));
        endcase
      end
      check_cycle();
      commit();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_wb_regfile.md
Name: dual_wb_regfile

Overview:
- Architectural register file at the receiving end of the dual-issue writeback bus. Consumes the two write channels packed on ws_to_rf_bus.
- Serves four read ports to the decode/issue stage, covering two instructions with two sources each.
- Maintains a per-register pending-write scoreboard: issue increments it, writeback decrements it, and issue uses it to stall on RAW hazards.
- Write-through bypass lets decode see same-cycle writeback data.

Parameters:
- CNT_W, 2, width of each per-register pending-write counter (max in-flight writers per register = 2^CNT_W - 1).
- WS_TO_RF_BUS_WD, 76, writeback bus width (fixed; listed for cross-checking against defines).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- ws_to_rf_bus  input  76  {we1[75], waddr1[74:70], wdata1[69:38], we2[37], waddr2[36:32], wdata2[31:0]}
- raddr0..raddr3  input  5 each  read addresses (0/1 = slot1 src1/src2, 2/3 = slot2 src1/src2)
- rdata0..rdata3  output  32 each  read data, combinational
- rbusy0..rbusy3  output  1 each  addressed register still has an outstanding writer after this cycle's writeback
- iss_valid1, iss_valid2  input  1 each  slot issues this cycle
- iss_we1, iss_we2  input  1 each  issued slot writes a GPR
- iss_dest1, iss_dest2  input  5 each  issued destination
- flush  input  1  pipeline flush: clear all pending counters
- sb_overflow  output  1  sticky: an increment hit a saturated counter

Behaviour:
- Reset (synchronous):
  - all 32 GPRs <= 0; all counters <= 0; sb_overflow <= 0.
  - With all raddr = 0 after reset: rdata = 0, rbusy = 0.
- r0:
  - Always reads 0 and is never busy.
  - Writes to r0 and issues with dest 0 are ignored; they do not touch counters.
- Writes:
  - At posedge, if we1 and waddr1 != 0: GPR[waddr1] <= wdata1. Same for channel 2.
  - If both channels write the same nonzero register, channel 2 (younger) wins.
- Read (combinational):
  - rdataN = 0 if raddrN == 0.
  - Else wdata2 if we2 && waddr2 == raddrN.
  - Else wdata1 if we1 && waddr1 == raddrN.
  - Else GPR[raddrN].
- Scoreboard, per register r, evaluated each cycle:
  - inc = (iss_valid1 && iss_we1 && iss_dest1 == r) + (iss_valid2 && iss_we2 && iss_dest2 == r), range 0..2.
  - dec = (we1 && waddr1 == r) + (we2 && waddr2 == r), range 0..2.
  - cnt[r] <= cnt[r] + inc - dec, computed at CNT_W+2 bits.
  - Result < 0 (writeback with no recorded issue): clamp to 0. This is a protocol error and the bench flags it.
  - Result > 2^CNT_W - 1: clamp to max and set sb_overflow <= 1.
- rbusyN = (cnt[raddrN] - dec[raddrN]) != 0.
  - The same-cycle writeback retires its pending write before the busy check.
  - Same-cycle issue increments are excluded; intra-group dependencies are the issue stage's job.
- Flush:
  - All counters <= 0 next cycle, overriding any same-cycle inc/dec.
  - GPR writes in the flush cycle still commit.
  - sb_overflow is unaffected by flush; only reset clears it.
- Reset mid-operation: reset takes priority over writes, issue and flush in the same cycle.
- Latency:
  - Write visible through the array on the cycle after the write edge.
  - Visible through the bypass in the same cycle.
  - Counter updates visible on the cycle after the edge.

Test Plan:
- Reset, then read r5 on all ports -> rdata = 0, rbusy = 0; write ch1 r5 = 0x12345678 -> same cycle rdata0 = 0x12345678 via bypass, next cycle still 0x12345678 from the array.
- Both channels write r7 (ch1 = 0xAAAA0000, ch2 = 0x5555FFFF) -> same-cycle and next-cycle reads of r7 return 0x5555FFFF.
- Write r0 = 0xFFFFFFFF on both channels -> r0 reads 0, rbusy = 0, no counter change.
- Issue slot1 dest r3 -> next cycle rbusy(r3) = 1; in the cycle the writeback of r3 arrives, rbusy(r3) = 0 and rdata = the write value; next cycle cnt(r3) = 0.
- Issue r9 on both slots in one cycle -> cnt = 2; one writeback -> rbusy still 1; second writeback -> 0. Simultaneous issue plus writeback of r9 keeps cnt unchanged.
- Issue r4 four times with CNT_W = 2 -> after the 4th, cnt holds at 3 and sb_overflow = 1. flush -> all rbusy = 0 and sb_overflow stays 1. reset -> sb_overflow = 0.
